// File: rtl/rv_perf_mon.sv
// rv_perf_mon: instruction-mix and instruction-length performance monitor.
// Counts fetched instructions per opcode class, attributes the cycles each
// instruction occupied to its class, and stops all statistics once the core
// repeatedly fetches the same PC (the program has parked itself in a loop).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | statistics update on every enabled cycle
// ST_HALT | program complete; statistics frozen, readback still live
module rv_perf_mon #(
  parameter int CNT_W       = 32,
  parameter int SATURATE    = 0,
  parameter int STUCK_LIMIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             fetch_valid,
  input  logic [6:0]       fetch_opcode,
  input  logic [31:0]      fetch_pc,
  input  logic             clr,
  input  logic [4:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted,
  output logic             overflow
);

  // Just wide enough to hold STUCK_LIMIT itself.
  localparam int SC_W = (STUCK_LIMIT < 1) ? 1 : $clog2(STUCK_LIMIT + 1);
  localparam logic [SC_W:0]    STUCK_MAX = (SC_W + 1)'(STUCK_LIMIT);
  localparam logic [SC_W:0]    SC_ONE    = (SC_W + 1)'(1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] class_count  [8];
  logic [CNT_W-1:0] class_cycles [8];
  logic [CNT_W-1:0] total_cycles;
  logic [CNT_W-1:0] total_instr;
  logic [CNT_W-1:0] cur_len;
  logic [CNT_W-1:0] last_len;
  logic [SC_W-1:0]  stuck_cnt;
  logic [31:0]      last_pc;
  logic [2:0]       prev_class;
  logic             tracking;

  logic [2:0]       cls;
  logic             active;
  logic             pc_match;
  logic [SC_W:0]    stuck_inc;
  logic             halt_hit;
  logic             accept;
  logic [CNT_W:0]   tc_sum, ti_sum, cc_sum, cy_sum, cl_sum;
  logic             ovf_set;
  logic [CNT_W-1:0] rd_mux;

  // Add with carry-out in the top bit; on carry the low bits either wrap
  // naturally or are forced to all-ones when saturating.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] a,
                                          input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_W] && (SATURATE != 0)) s = {1'b1, {CNT_W{1'b1}}};
    return s;
  endfunction

  // Opcode class decode of the instruction being fetched.
  always_comb begin
    cls = 3'd7;
    case (fetch_opcode)
      7'b0110011: cls = 3'd0;
      7'b0010011: cls = 3'd1;
      7'b0000011: cls = 3'd2;
      7'b0100011: cls = 3'd3;
      7'b1100011: cls = 3'd4;
      7'b1101111: cls = 3'd5;
      7'b0110111: cls = 3'd6;
      default:    cls = 3'd7;
    endcase
  end

  // Qualify the fetch: a repeat fetch that reaches the limit halts instead of counting.
  always_comb begin
    active    = en && (state == ST_RUN);
    pc_match  = (fetch_pc == last_pc);
    stuck_inc = {1'b0, stuck_cnt} + SC_ONE;
    halt_hit  = active && fetch_valid && pc_match && (stuck_inc == STUCK_MAX);
    accept    = active && fetch_valid && !halt_hit;
  end

  // Candidate counter updates and the overflow they would raise.
  always_comb begin
    tc_sum  = bump(total_cycles, ONE);
    ti_sum  = bump(total_instr, ONE);
    cc_sum  = bump(class_count[cls], ONE);
    cy_sum  = bump(class_cycles[prev_class], cur_len);
    cl_sum  = bump(cur_len, ONE);
    ovf_set = tc_sum[CNT_W]
            | (accept  & (ti_sum[CNT_W] | cc_sum[CNT_W] | (tracking & cy_sum[CNT_W])))
            | (!accept & cl_sum[CNT_W]);
  end

  // Halt state register; clr releases a halt.
  always_ff @(posedge clk) begin
    if (!reset)   state <= ST_RUN;
    else if (clr) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Halt next-state: once halted, stay until reset or clr.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (halt_hit) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
    endcase
  end

  assign halted = (state == ST_HALT);

  // Statistics, length tracking and stuck-PC detection.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      for (int i = 0; i < 8; i++) begin
        class_count[i]  <= '0;
        class_cycles[i] <= '0;
      end
      total_cycles <= '0;
      total_instr  <= '0;
      cur_len      <= '0;
      last_len     <= '0;
      stuck_cnt    <= '0;
      last_pc      <= 32'hFFFF_FFFF;
      prev_class   <= 3'd0;
      tracking     <= 1'b0;
      overflow     <= 1'b0;
    end else if (active) begin
      total_cycles <= tc_sum[CNT_W-1:0];
      if (fetch_valid) begin
        if (pc_match) begin
          stuck_cnt <= stuck_inc[SC_W-1:0];
        end else begin
          stuck_cnt <= '0;
          last_pc   <= fetch_pc;
        end
      end
      if (accept) begin
        total_instr      <= ti_sum[CNT_W-1:0];
        class_count[cls] <= cc_sum[CNT_W-1:0];
        // The length just closed belongs to the previous instruction.
        if (tracking) begin
          class_cycles[prev_class] <= cy_sum[CNT_W-1:0];
          last_len                 <= cur_len;
        end
        cur_len    <= ONE;
        prev_class <= cls;
        tracking   <= 1'b1;
      end else begin
        cur_len <= cl_sum[CNT_W-1:0];
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // Readback select.
  always_comb begin
    rd_mux = '0;
    case (rd_sel[4:3])
      2'b00: rd_mux = class_count[rd_sel[2:0]];
      2'b01: rd_mux = class_cycles[rd_sel[2:0]];
      2'b10: begin
        case (rd_sel[2:0])
          3'd0:    rd_mux = total_cycles;
          3'd1:    rd_mux = total_instr;
          3'd2:    rd_mux = last_len;
          default: rd_mux = '0;
        endcase
      end
      default: rd_mux = '0;
    endcase
  end

  // Registered readback; clr leaves it alone so the old values drain out one edge later.
  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_rv_perf_mon.sv
// Bench for rv_perf_mon: directed scenarios plus a randomized run, all checked
// against a behavioural model of the counters kept in plain arrays.
module tb_rv_perf_mon;

  localparam int          LIMIT = 2;
  localparam longint unsigned MASK = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [6:0]  fetch_opcode = 7'd0;
  logic [31:0] fetch_pc = 32'd0;
  logic        clr = 1'b0;
  logic [4:0]  rd_sel = 5'd0;
  logic [31:0] rd_data;
  logic        halted, overflow;

  logic        en4 = 1'b0;
  logic        fv4 = 1'b0;
  logic        clr4 = 1'b0;
  logic [4:0]  rd_sel4 = 5'd0;
  logic [3:0]  rd4w, rd4s;
  logic        h4w, h4s, o4w, o4s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_perf_mon #(.CNT_W(32), .SATURATE(0), .STUCK_LIMIT(LIMIT)) u_dut (
    .clk(clk), .reset(reset), .en(en), .fetch_valid(fetch_valid),
    .fetch_opcode(fetch_opcode), .fetch_pc(fetch_pc), .clr(clr),
    .rd_sel(rd_sel), .rd_data(rd_data), .halted(halted), .overflow(overflow));

  rv_perf_mon #(.CNT_W(4), .SATURATE(0), .STUCK_LIMIT(LIMIT)) u_w4_wrap (
    .clk(clk), .reset(reset), .en(en4), .fetch_valid(fv4),
    .fetch_opcode(fetch_opcode), .fetch_pc(fetch_pc), .clr(clr4),
    .rd_sel(rd_sel4), .rd_data(rd4w), .halted(h4w), .overflow(o4w));

  rv_perf_mon #(.CNT_W(4), .SATURATE(1), .STUCK_LIMIT(LIMIT)) u_w4_sat (
    .clk(clk), .reset(reset), .en(en4), .fetch_valid(fv4),
    .fetch_opcode(fetch_opcode), .fetch_pc(fetch_pc), .clr(clr4),
    .rd_sel(rd_sel4), .rd_data(rd4s), .halted(h4s), .overflow(o4s));

  // Reference model state.
  longint unsigned m_cc [8];
  longint unsigned m_cy [8];
  longint unsigned m_tc, m_ti, m_cur, m_last;
  longint unsigned m_lastpc;
  int              m_stuck, m_prev;
  bit              m_track, m_halt, m_ovf;
  longint unsigned exp_rd;
  logic [6:0]      ops [7];

  task automatic chk(input string tag, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b0110111: return 6;
      default:    return 7;
    endcase
  endfunction

  function automatic longint unsigned m_add(input longint unsigned a, input longint unsigned b);
    longint unsigned s;
    s = a + b;
    if (s > MASK) begin
      m_ovf = 1'b1;
      s = s & MASK;
    end
    return s;
  endfunction

  function automatic longint unsigned m_sel(input int s);
    if (s < 8)  return m_cc[s];
    if (s < 16) return m_cy[s - 8];
    if (s == 16) return m_tc;
    if (s == 17) return m_ti;
    if (s == 18) return m_last;
    return 0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) begin
      m_cc[i] = 0;
      m_cy[i] = 0;
    end
    m_tc = 0; m_ti = 0; m_cur = 0; m_last = 0;
    m_lastpc = 64'hFFFF_FFFF;
    m_stuck = 0; m_prev = 0;
    m_track = 0; m_halt = 0; m_ovf = 0;
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_step();
    bit acc;
    int c;
    if (!reset) begin
      m_clear();
      exp_rd = 0;
      return;
    end
    exp_rd = m_sel(int'(rd_sel));
    if (clr) begin
      m_clear();
      return;
    end
    if (!en || m_halt) return;
    m_tc = m_add(m_tc, 1);
    acc = 0;
    if (fetch_valid) begin
      if (longint'(fetch_pc) == m_lastpc) begin
        m_stuck++;
        if (m_stuck == LIMIT) m_halt = 1;
        else acc = 1;
      end else begin
        m_stuck = 0;
        m_lastpc = longint'(fetch_pc);
        acc = 1;
      end
    end
    if (acc) begin
      c = cls_of(fetch_opcode);
      m_ti = m_add(m_ti, 1);
      m_cc[c] = m_add(m_cc[c], 1);
      if (m_track) begin
        m_cy[m_prev] = m_add(m_cy[m_prev], m_cur);
        m_last = m_cur;
      end
      m_cur = 1;
      m_prev = c;
      m_track = 1;
    end else begin
      m_cur = m_add(m_cur, 1);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("rd_data", rd_data, exp_rd);
    chk("halted", halted, m_halt);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic do_reset();
    reset = 1'b0; en = 1'b0; fetch_valid = 1'b0; clr = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic fetch(input logic [6:0] op, input logic [31:0] pc);
    en = 1'b1; fetch_valid = 1'b1; fetch_opcode = op; fetch_pc = pc;
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b1; fetch_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic read_const(input string tag, input int sel, input longint unsigned exp);
    en = 1'b0; fetch_valid = 1'b0; rd_sel = 5'(sel);
    step();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    ops[6] = 7'b0110111;
    m_clear();
    exp_rd = 0;

    // Reset state.
    do_reset();
    chk("reset_rd", rd_data, 0);
    chk("reset_halted", halted, 0);
    chk("reset_ovf", overflow, 0);

    // Three R-type fetches, four cycles apart.
    do_reset();
    fetch(ops[0], 32'h0); idle(3);
    fetch(ops[0], 32'h4); idle(3);
    fetch(ops[0], 32'h8); idle(3);
    read_const("r_count", 0, 3);
    read_const("r_cycles", 8, 8);
    read_const("r_last_len", 18, 4);
    read_const("r_instr", 17, 3);

    // LUI (3 cycles), LW (5 cycles), BEQ.
    do_reset();
    fetch(ops[6], 32'h100); idle(2);
    fetch(ops[2], 32'h104); idle(4);
    fetch(ops[4], 32'h108);
    read_const("lui_cycles", 14, 3);
    read_const("lw_cycles", 10, 5);
    read_const("beq_count", 4, 1);

    // Same PC three times halts and the third fetch is not counted.
    do_reset();
    fetch(ops[0], 32'h20);
    fetch(ops[0], 32'h20);
    fetch(ops[0], 32'h20);
    chk("stuck_halted", halted, 1);
    idle(3);
    read_const("stuck_instr", 17, 2);
    read_const("stuck_cycles", 16, 3);
    read_const("stuck_rcount", 0, 2);

    // en gap between two fetches three active cycles apart.
    do_reset();
    fetch(ops[1], 32'h40); idle(2);
    en = 1'b0; repeat (5) step();
    fetch(ops[1], 32'h44);
    read_const("gap_last_len", 18, 3);
    read_const("gap_cycles", 16, 4);

    // clr together with a fetch after ten instructions.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fetch(ops[i % 7], 32'h200 + 32'(i * 4));
      idle(1);
    end
    en = 1'b1; clr = 1'b1; fetch_valid = 1'b1; fetch_opcode = ops[0]; fetch_pc = 32'h300;
    step();
    clr = 1'b0; fetch_valid = 1'b0;
    chk("clr_halted", halted, 0);
    for (int s = 0; s < 19; s++) read_const("clr_zero", s, 0);
    fetch(ops[0], 32'h304); idle(2);
    for (int s = 8; s < 16; s++) read_const("clr_no_attr", s, 0);
    read_const("clr_last_len", 18, 0);
    read_const("clr_instr", 17, 1);

    // Narrow counters: 17 active cycles, wrapping vs saturating.
    do_reset();
    chk("w4_reset", rd4w, 0);
    en4 = 1'b1;
    repeat (17) step();
    en4 = 1'b0; rd_sel4 = 5'd16;
    step();
    chk("w4_wrap_cycles", rd4w, 1);
    chk("w4_sat_cycles", rd4s, 15);
    chk("w4_wrap_ovf", o4w, 1);
    chk("w4_sat_ovf", o4s, 1);

    // Randomized run.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int k;
      reset = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      fetch_valid = ($urandom_range(0, 9) < 4);
      k = $urandom_range(0, 7);
      fetch_opcode = (k < 7) ? ops[k] : 7'($urandom);
      fetch_pc = 32'($urandom_range(0, 3) * 4);
      rd_sel = 5'($urandom_range(0, 31));
      step();
    end
    reset = 1'b1; clr = 1'b0; fetch_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_perf_mon.md
RV_PERF_MON -- requirements
Module: rv_perf_mon

Interface
REQ-001 Parameter CNT_W, default 32: width of every counter and of rd_data.
REQ-002 Parameter SATURATE, default 0: 0 = counters wrap, 1 = counters stick at all-ones.
REQ-003 Parameter STUCK_LIMIT, default 2: number of consecutive same-PC repeat fetches that declares halt.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 en  input  1  counting enable; when low, no counter, length or stuck state changes.
REQ-007 fetch_valid  input  1  one-cycle strobe, the cycle the core latches a new instruction.
REQ-008 fetch_opcode  input  7  instr[6:0] of the instruction being fetched, valid with fetch_valid.
REQ-009 fetch_pc  input  32  PC of the instruction being fetched, valid with fetch_valid.
REQ-010 clr  input  1  synchronous clear of all statistics.
REQ-011 rd_sel  input  5  readback select.
REQ-012 rd_data  output  CNT_W  registered readback value.
REQ-013 halted  output  1  program-complete flag, sticky.
REQ-014 overflow  output  1  sticky flag: some counter exceeded its maximum.

Function
REQ-015 Opcode class map: 0110011->0 R-type, 0010011->1 I-arith, 0000011->2 load, 0100011->3 store, 1100011->4 branch, 1101111->5 JAL, 0110111->6 LUI, any other->7 other.
REQ-016 Active cycle: en=1 and registered halted=0; only active cycles change statistics.
REQ-017 total_cycles SHALL increment by 1 on every active cycle.
REQ-018 An accepted fetch is fetch_valid=1 on an active cycle that does not set halted.
REQ-019 On an accepted fetch: total_instr +1 and class_count[class(fetch_opcode)] +1.
REQ-020 cur_len SHALL load 1 on an accepted fetch and increment by 1 on every other active cycle.
REQ-021 On an accepted fetch with tracking=1: class_cycles[prev_class] += cur_len, and last_len <= cur_len (the value before reload).
REQ-022 On an accepted fetch: prev_class <= class(fetch_opcode) and tracking <= 1.
REQ-023 The first accepted fetch after reset or clr attributes nothing; tracking is 0 at that point.
REQ-024 Stuck detection on each fetch_valid in an active cycle:
  - fetch_pc equal to last_pc: stuck_cnt +1.
  - otherwise: stuck_cnt <= 0 and last_pc <= fetch_pc.
REQ-025 last_pc resets to 0xFFFFFFFF.
REQ-026 When the increment in REQ-024 makes stuck_cnt reach STUCK_LIMIT: halted <= 1, and that fetch is not accepted (no count, no attribution).
REQ-027 Once halted=1, all statistics freeze until reset or clr; readback keeps working.
REQ-028 Counter overflow:
  - SATURATE=0: the counter wraps modulo 2^CNT_W.
  - SATURATE=1: the counter holds all-ones.
  - Either mode: overflow <= 1.
REQ-029 class_cycles addition follows REQ-028 on the full sum (an add past the maximum saturates or wraps; it is never truncated in any other way).
REQ-030 rd_data <= value selected by rd_sel at the previous edge (1-cycle latency):
  - 0-7: class_count[n].
  - 8-15: class_cycles[n-8].
  - 16: total_cycles.
  - 17: total_instr.
  - 18: last_len.
  - 19-31: zero.
REQ-031 rd_data is zero-extended or truncated to CNT_W where needed.
REQ-032 clr=1 SHALL zero all counters, cur_len, last_len, stuck_cnt, tracking, halted and overflow, and set last_pc to 0xFFFFFFFF.
REQ-033 clr has priority over a simultaneous fetch_valid; that fetch is discarded.
REQ-034 clr does not reset rd_data; rd_data reflects the cleared values from the next edge.

Reset
REQ-035 reset=0 at a rising edge SHALL apply REQ-032 and also set rd_data to 0.
REQ-036 reset has priority over clr, en and fetch_valid.
REQ-037 Reset mid-instruction discards the open instruction length; nothing is attributed.

Verification
REQ-038 Fetch R at PCs 0, 4 and 8, each 4 cycles apart -> class_count[0]=3, class_cycles[0]=8, last_len=4, total_instr=3.
REQ-039 Fetch LUI (3 cycles), then LW (5 cycles), then BEQ -> class_cycles[6]=3, class_cycles[2]=5, class_count[4]=1.
REQ-040 Fetch PC 0x20 three times in a row with STUCK_LIMIT=2:
  - halted=1 after the third fetch.
  - That fetch is not counted.
  - total_cycles frozen on the following cycles.
REQ-041 CNT_W=4 and 17 active cycles:
  - SATURATE=0 -> total_cycles=1, overflow=1.
  - SATURATE=1 -> total_cycles=15, overflow=1.
REQ-042 en=0 for 5 cycles between two fetches 3 active cycles apart -> last_len=3 and total_cycles unaffected by the gap.
REQ-043 Assert clr in the same cycle as fetch_valid, after 10 instructions -> next cycle all reads 0 and halted=0; the next fetch attributes nothing.
